// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch/PC sequencing slice.
// Imported by fetch_unit and pc_next_calc.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    localparam logic [6:0]  OPC_HLT      = 7'b000_0000;
    localparam int          PC_STEP      = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC arithmetic: sequential step or branch target,
// always word aligned, wrapping modulo 2^XLEN.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic            pcsrc_i,
    input  logic            resume_i,
    output logic [XLEN-1:0] next_pc_o
);

    logic [XLEN-1:0] sum;

    // Resume from halt always steps past the HLT word.
    always_comb begin
        if (pcsrc_i && !resume_i) begin
            sum = pc_i + imm_i;
        end else begin
            sum = pc_i + XLEN'(PC_STEP);
        end
        next_pc_o = sum & ~XLEN'(3);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: owns the PC, handshakes with imem,
// presents each word for one execute cycle, halts on HLT.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ack,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    input  logic            PCSrc,
    input  logic            load,
    input  logic [XLEN-1:0] ImmExt,
    input  logic            resume,
    output logic            halted
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_nxt;

    pc_next_calc #(
        .XLEN(XLEN)
    ) u_pc_next (
        .pc_i     (pc_q),
        .imm_i    (ImmExt),
        .pcsrc_i  (PCSrc),
        .resume_i (state_q == HALTED),
        .next_pc_o(pc_nxt)
    );

    // State, PC and instruction registers; reset wins over any event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Next-state logic; control inputs only matter in EXEC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!load) begin
                    state_d = HALTED;
                end else begin
                    pc_d    = pc_nxt;
                    state_d = FETCH;
                end
            end
            HALTED: begin
                if (resume) begin
                    pc_d    = pc_nxt;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == EXEC);
    assign halted      = (state_q == HALTED);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit plus reset-collision
// and PC-wrap sequences.
module tb_fetch_unit;

    localparam logic [31:0] ADD  = 32'h0020_81B3;
    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] SW   = 32'h0020_A023;
    localparam logic [31:0] BEQ  = 32'h0020_8463;
    localparam logic [31:0] HLT  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        PCSrc = 1'b0;
    logic        load = 1'b1;
    logic [31:0] ImmExt = '0;
    logic        resume = 1'b0;

    logic        imem_req, instr_valid, halted;
    logic [31:0] imem_addr, instr, pc;
    logic        w_req, w_valid, w_halted;
    logic [31:0] w_addr, w_instr, w_pc;

    int checks = 0;
    int errors = 0;
    int vi = -1;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .instr(instr), .instr_valid(instr_valid), .pc(pc),
        .PCSrc(PCSrc), .load(load), .ImmExt(ImmExt),
        .resume(resume), .halted(halted)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .instr(w_instr), .instr_valid(w_valid), .pc(w_pc),
        .PCSrc(PCSrc), .load(load), .ImmExt(ImmExt),
        .resume(resume), .halted(w_halted)
    );

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        pcsrc;
        logic        ld;
        logic [31:0] imm;
        logic        res;
        logic        req;
        logic        valid;
        logic        hlt;
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic a, input logic [31:0] rd,
                       input logic ps, input logic ld,
                       input logic [31:0] im, input logic rs,
                       input logic eq, input logic ev,
                       input logic eh, input logic [31:0] ep,
                       input logic [31:0] ei);
        vec_t v;
        v.ack = a; v.rdata = rd; v.pcsrc = ps; v.ld = ld;
        v.imm = im; v.res = rs; v.req = eq; v.valid = ev;
        v.hlt = eh; v.pc = ep; v.instr = ei;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %h want %h",
                     name, vi, act, exp);
        end
    endtask

    task automatic chk_main(input logic eq, input logic ev,
                            input logic eh, input logic [31:0] ep,
                            input logic [31:0] ei);
        chk("imem_req", 32'(imem_req), 32'(eq));
        chk("instr_valid", 32'(instr_valid), 32'(ev));
        chk("halted", 32'(halted), 32'(eh));
        chk("pc", pc, ep);
        chk("imem_addr", imem_addr, ep);
        chk("instr", instr, ei);
    endtask

    initial begin
        // sequential run 0,4,8,C,10
        add(1, ADD,  0, 1, 0, 0,  1, 0, 0, 32'h0,  32'h0);
        add(0, 0,    0, 1, 0, 0,  0, 1, 0, 32'h0,  ADD);
        add(1, ADDI, 0, 1, 0, 0,  1, 0, 0, 32'h4,  ADD);
        add(0, 0,    0, 1, 0, 0,  0, 1, 0, 32'h4,  ADDI);
        add(1, SW,   0, 1, 0, 0,  1, 0, 0, 32'h8,  ADDI);
        add(0, 0,    0, 1, 0, 0,  0, 1, 0, 32'h8,  SW);
        add(1, ADD,  0, 1, 0, 0,  1, 0, 0, 32'hC,  SW);
        add(0, 0,    0, 1, 0, 0,  0, 1, 0, 32'hC,  ADD);
        add(1, BEQ,  0, 1, 0, 0,  1, 0, 0, 32'h10, ADD);
        // BEQ at 0x10, offset -8 -> 0x08
        add(0, 0, 1, 1, 32'hFFFF_FFF8, 0, 0, 1, 0, 32'h10, BEQ);
        add(1, BEQ,  0, 1, 0, 0,  1, 0, 0, 32'h8,  BEQ);
        // BEQ at 0x08, offset +8 -> 0x10
        add(0, 0, 1, 1, 32'h8, 0, 0, 1, 0, 32'h8, BEQ);
        add(1, BEQ,  0, 1, 0, 0,  1, 0, 0, 32'h10, BEQ);
        // 0x10 + 0x7FE = 0x80E -> aligned 0x80C
        add(0, 0, 1, 1, 32'h7FE, 0, 0, 1, 0, 32'h10, BEQ);
        // three wait states, resume while running ignored
        add(0, 0,    0, 1, 0, 1,  1, 0, 0, 32'h80C, BEQ);
        add(0, 0,    0, 1, 0, 0,  1, 0, 0, 32'h80C, BEQ);
        add(0, 0,    0, 1, 0, 0,  1, 0, 0, 32'h80C, BEQ);
        add(1, ADDI, 0, 1, 0, 0,  1, 0, 0, 32'h80C, BEQ);
        add(0, 0,    0, 1, 0, 1,  0, 1, 0, 32'h80C, ADDI);
        add(1, BEQ,  0, 1, 0, 0,  1, 0, 0, 32'h810, ADDI);
        // 0x810 - 0x7F0 -> 0x20
        add(0, 0, 1, 1, 32'hFFFF_F810, 0, 0, 1, 0, 32'h810, BEQ);
        add(1, HLT,  0, 1, 0, 0,  1, 0, 0, 32'h20, BEQ);
        // HLT executes: load=0 wins over PCSrc
        add(0, 0,    1, 0, 4, 0,  0, 1, 0, 32'h20, HLT);
        for (int k = 0; k < 10; k++) begin
            add(1, ADD, 1, 1, 4, (k == 9), 0, 0, 1, 32'h20, HLT);
        end
        add(1, ADD,  0, 1, 0, 0,  1, 0, 0, 32'h24, HLT);
        add(0, 0,    0, 1, 0, 0,  0, 1, 0, 32'h24, ADD);

        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            vi         = i;
            rst        = 1'b0;
            imem_ack   = tbl[i].ack;
            imem_rdata = tbl[i].rdata;
            PCSrc      = tbl[i].pcsrc;
            load       = tbl[i].ld;
            ImmExt     = tbl[i].imm;
            resume     = tbl[i].res;
            chk_main(tbl[i].req, tbl[i].valid, tbl[i].hlt,
                     tbl[i].pc, tbl[i].instr);
        end

        // reset during FETCH with simultaneous ack
        @(negedge clk);
        vi = 100;
        imem_ack = 1'b0; load = 1'b1; PCSrc = 1'b0; resume = 1'b0;
        chk_main(1, 0, 0, 32'h28, ADD);
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = SW;
        @(negedge clk);
        vi = 101;
        rst = 1'b0; imem_ack = 1'b0;
        chk_main(1, 0, 0, 32'h0, 32'h0);

        // reset during EXEC with a taken branch
        imem_ack = 1'b1; imem_rdata = ADD;
        @(negedge clk);
        vi = 102;
        chk_main(0, 1, 0, 32'h0, ADD);
        imem_ack = 1'b0; rst = 1'b1;
        load = 1'b1; PCSrc = 1'b1; ImmExt = 32'h100;
        @(negedge clk);
        vi = 103;
        rst = 1'b0; PCSrc = 1'b0; ImmExt = '0;
        chk_main(1, 0, 0, 32'h0, 32'h0);

        // reset during HALTED with resume
        imem_ack = 1'b1; imem_rdata = HLT;
        @(negedge clk);
        vi = 104;
        imem_ack = 1'b0; load = 1'b0;
        chk_main(0, 1, 0, 32'h0, HLT);
        @(negedge clk);
        vi = 105;
        load = 1'b1;
        chk_main(0, 0, 1, 32'h0, HLT);
        rst = 1'b1; resume = 1'b1;
        @(negedge clk);
        vi = 106;
        rst = 1'b0; resume = 1'b0;
        chk_main(1, 0, 0, 32'h0, 32'h0);

        // PC wrap on the second instance
        rst = 1'b1;
        @(negedge clk);
        vi = 200;
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = ADDI;
        chk("wrap pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap addr", w_addr, 32'hFFFF_FFFC);
        chk("wrap req", 32'(w_req), 32'h1);
        chk("wrap instr", w_instr, 32'h0);
        @(negedge clk);
        vi = 201;
        imem_ack = 1'b0; load = 1'b1; PCSrc = 1'b0;
        chk("wrap valid", 32'(w_valid), 32'h1);
        chk("wrap instr", w_instr, ADDI);
        @(negedge clk);
        vi = 202;
        chk("wrap pc", w_pc, 32'h0);
        chk("wrap addr", w_addr, 32'h0);
        chk("wrap req", 32'(w_req), 32'h1);
        chk("wrap halted", 32'(w_halted), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and PC-sequencing block: the producer of every instruction word the control unit decodes, and the consumer of its `PCSrc` and `load` outputs. It owns the program counter and issues requests to instruction memory over a request/acknowledge handshake. It presents each fetched word for exactly one execute cycle, then advances the PC sequentially, takes a branch, or parks in a halt state when the control unit deasserts `load` (HLT, opcode 0).

## Interface
- `XLEN`, 32, datapath/PC width
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  XLEN  fetch address, always equal to `pc`
- `imem_rdata`  in  32  instruction word, valid when `imem_ack`=1
- `imem_ack`  in  1  memory completion strobe; ignored unless `imem_req`=1
- `instr`  out  32  registered instruction word to decoder/register file
- `instr_valid`  out  1  execute strobe; high for exactly one cycle per instruction
- `pc`  out  XLEN  address of the instruction in `instr`
- `PCSrc`  in  1  branch taken (from control unit, combinational on `instr`)
- `load`  in  1  0 = HLT decoded (from control unit)
- `ImmExt`  in  XLEN  sign-extended branch offset
- `resume`  in  1  single-cycle pulse restarting a halted core
- `halted`  out  1  core parked on HLT

## Operation
- States: FETCH, EXEC, HALTED. Reset: state=FETCH, `pc`=RESET_PC, `instr`=0, `instr_valid`=0, `halted`=0.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On `imem_ack`: `instr`<=`imem_rdata`, go to EXEC. No ack means remain, unbounded wait, `pc` stable.
- EXEC: `imem_req`=0, `instr_valid`=1. `PCSrc`/`load`/`ImmExt` sampled this cycle only.
  - `load`=0: go to HALTED, `pc` unchanged (points at HLT), `instr` held.
  - `load`=1, `PCSrc`=1: `pc`<=(`pc`+`ImmExt`) with bits [1:0] forced to 0; go to FETCH.
  - `load`=1, `PCSrc`=0: `pc`<=`pc`+4; go to FETCH.
- HALTED: `halted`=1, `imem_req`=0, `instr_valid`=0, `instr` and `pc` held. On `resume`: `pc`<=`pc`+4, go to FETCH. `resume` in any other state is ignored.
- Arithmetic: all PC additions are modulo 2^XLEN. 32'hFFFF_FFFC+4 wraps to 0. Negative `ImmExt` is two's complement.
- `PCSrc`, `load` and `ImmExt` outside EXEC are don't-care.

## Timing
- Minimum 2 cycles per instruction: req/ack in cycle N (FETCH), execute in N+1 (EXEC), next request in N+2.
- `imem_req`, `instr_valid` and `halted` are Moore outputs decoded from state.
- `instr` changes only on the clock edge ending an acked FETCH cycle.
- Reset dominates: `rst`=1 coincident with `imem_ack`, `resume` or EXEC discards that event. The next cycle is FETCH at RESET_PC with `imem_req`=1.
- Reset mid-wait: an outstanding request is abandoned. The memory must tolerate `imem_req` dropping for one cycle. A late ack on the cycle the reset is applied is ignored.
- `halted` rises the cycle after the EXEC of HLT and falls the cycle after `resume`.

## Structure
- Shared package `cpu_pkg`: state enum (FETCH, EXEC, HALTED), `OPC_HLT`=7'b000_0000, `PC_STEP`=4, default `RESET_PC`.
- One sub-module, `pc_next_calc`, is natural. It is combinational: takes `pc`, `ImmExt`, `PCSrc` and a halt-resume flag, and returns the next PC with bits [1:0] cleared.
- The FSM and the `pc`/`instr` registers stay in `fetch_unit`.

## Test plan
- Sequential run: memory with zero-wait ack, words ADD/ADDI/SW at 0, 4, 8 -> `imem_addr` 0, 4, 8 on alternate cycles, `instr_valid` pulses 1 cycle each, `pc` matches each word.
- Branch taken: BEQ at 0x10, `PCSrc`=1, `ImmExt`=-8 -> next `imem_addr`=0x08. Repeat with `ImmExt`=0x7FE -> 0x80C (bits [1:0] cleared).
- Wait states: ack delayed 3 cycles -> `imem_req` high 4 cycles, `pc`/`imem_addr` constant, one `instr_valid`.
- Halt/resume: word 0 at 0x20 (`load`=0) -> `halted`=1 from next cycle, `pc`=0x20, no requests for 10 cycles. `resume` pulse -> fetch at 0x24. `resume` while running has no effect.
- Wrap: `RESET_PC`=32'hFFFF_FFFC, non-branch word -> next fetch at 0x0000_0000.
- Reset collisions: `rst` asserted during FETCH with simultaneous ack, during EXEC, and during HALTED with `resume` -> next cycle `pc`=RESET_PC, FETCH, `instr`=0, `instr_valid`=0, `halted`=0.
